// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and a clog2 helper.
package uart_pkg;

   localparam int unsigned NB_BYTE       = 8;
   localparam int unsigned NB_FRAME_BITS = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((64'd1 << result) < 64'(value)) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push while full is accepted only
// when a pop retires a word on the same edge.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_en;
   logic             rd_en;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      rd_en    = pop & ~empty;
      wr_en    = push & (~full | rd_en);
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(wr_en) - CW'(rd_en);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: contents are only observable through count_q.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/result_uart_tx.sv
// Result sink: buffers processor result words and sends each as two 8N1 bytes,
// low byte first, on a registered TX line.
module result_uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned NB_DATA    = 16,
   parameter int unsigned CLK_FREQ   = 10_000_000,
   parameter int unsigned BAUD_RATE  = 19200,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_valid,
   output logic               o_tx,
   output logic               o_busy,
   output logic               o_fifo_full,
   output logic               o_overflow
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int unsigned BAUD_W       = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);

   uart_state_e        state_q, state_d;
   logic [BAUD_W-1:0]  baud_q, baud_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic               byte_sel_q, byte_sel_d;
   logic [NB_DATA-1:0] word_q, word_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               full_q, full_d;
   logic               overflow_q, overflow_d;

   logic               fifo_pop;
   logic [NB_DATA-1:0] fifo_rdata;
   logic               fifo_empty;
   logic               fifo_full;
   logic               baud_done;
   logic [NB_BYTE-1:0] cur_byte;

   sync_fifo #(
      .WIDTH (NB_DATA),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .push    (i_valid),
      .pop     (fifo_pop),
      .wdata   (i_data),
      .rdata   (fifo_rdata),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign cur_byte  = byte_sel_q ? word_q[NB_DATA-1 -: NB_BYTE] : word_q[NB_BYTE-1:0];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         byte_sel_q <= 1'b0;
         word_q     <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         byte_sel_q <= byte_sel_d;
         word_q     <= word_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

   // Next state: frame sequencing, baud timing and FIFO pops.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_done ? '0 : baud_q + BAUD_W'(1);
      bit_idx_d  = bit_idx_q;
      byte_sel_d = byte_sel_q;
      word_d     = word_q;
      fifo_pop   = 1'b0;
      unique case (state_q)
         IDLE: begin
            baud_d    = '0;
            bit_idx_d = '0;
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               word_d     = fifo_rdata;
               byte_sel_d = 1'b0;
               state_d    = START;
            end
         end
         START: begin
            if (baud_done) state_d = DATA;
         end
         DATA: begin
            if (baud_done) begin
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (baud_done) begin
               if (!byte_sel_q) begin
                  byte_sel_d = 1'b1;
                  state_d    = START;
               end else if (!fifo_empty) begin
                  // Chain straight into the next word with no idle gap.
                  fifo_pop   = 1'b1;
                  word_d     = fifo_rdata;
                  byte_sel_d = 1'b0;
                  state_d    = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: line level from the current state, status flags.
   always_comb begin
      tx_d       = 1'b1;
      busy_d     = (state_q != IDLE) | ~fifo_empty;
      full_d     = fifo_full;
      overflow_d = overflow_q | (i_valid & fifo_full & ~fifo_pop);
      unique case (state_q)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = cur_byte[bit_idx_q];
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   assign o_tx        = tx_q;
   assign o_busy      = busy_q;
   assign o_fifo_full = full_q;
   assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench for result_uart_tx: a UART receiver model decodes the line
// and compares each word against the queue of accepted pushes.
module tb_result_uart_tx;

   localparam int unsigned CPB = 10;

   logic        clk = 1'b0;
   logic        i_reset;
   logic [15:0] i_data;
   logic        i_valid;
   logic        o_tx;
   logic        o_busy;
   logic        o_fifo_full;
   logic        o_overflow;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int unsigned push_cyc = 0;
   int          rx_words = 0;
   logic [15:0] sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   result_uart_tx #(
      .NB_DATA    (16),
      .CLK_FREQ   (1000),
      .BAUD_RATE  (100),
      .FIFO_DEPTH (8)
   ) dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_data      (i_data),
      .i_valid     (i_valid),
      .o_tx        (o_tx),
      .o_busy      (o_busy),
      .o_fifo_full (o_fifo_full),
      .o_overflow  (o_overflow)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Receiver model: mid-bit sampling on the falling clock edge.
   initial begin
      bit          rx_active = 1'b0;
      bit          have_low  = 1'b0;
      int          rx_t      = 0;
      int          k;
      int unsigned rx_start  = 0;
      int unsigned low_start = 0;
      logic [7:0]  rx_shift  = 8'h00;
      logic [7:0]  low_byte  = 8'h00;
      logic [15:0] word;
      logic [15:0] exp_word;
      forever begin
         @(negedge clk);
         if (i_reset) begin
            rx_active = 1'b0;
            have_low  = 1'b0;
         end else if (!rx_active) begin
            if (o_tx == 1'b0) begin
               rx_active = 1'b1;
               rx_t      = 0;
               rx_start  = cyc;
            end
         end else begin
            rx_t++;
            if ((rx_t % CPB) == (CPB / 2)) begin
               k = rx_t / CPB;
               if (k == 0) begin
                  check_eq("start_bit", 32'(o_tx), 32'd0);
               end else if (k <= 8) begin
                  rx_shift[k-1] = o_tx;
               end else begin
                  check_eq("stop_bit", 32'(o_tx), 32'd1);
                  rx_active = 1'b0;
                  if (!have_low) begin
                     low_byte  = rx_shift;
                     low_start = rx_start;
                     have_low  = 1'b1;
                  end else begin
                     have_low = 1'b0;
                     check_eq("byte_gap", rx_start - low_start, 32'(10 * CPB));
                     word = {rx_shift, low_byte};
                     rx_words++;
                     check_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                     if (sb_q.size() > 0) begin
                        exp_word = sb_q.pop_front();
                        check_eq("rx_word", 32'(word), 32'(exp_word));
                     end
                  end
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      i_reset = 1'b1;
      i_valid = 1'b0;
      sb_q.delete();
      repeat (4) begin
         @(posedge clk);
         #1;
         check_eq("reset_tx", 32'(o_tx), 32'd1);
         check_eq("reset_busy", 32'(o_busy), 32'd0);
         check_eq("reset_ovf", 32'(o_overflow), 32'd0);
      end
      @(negedge clk);
      i_reset = 1'b0;
   endtask

   task automatic push_word(input logic [15:0] w, input bit accept);
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = w;
      if (accept) sb_q.push_back(w);
      @(posedge clk);
      #1;
      push_cyc = cyc;
      i_valid  = 1'b0;
   endtask

   task automatic wait_fall(input int max, output int unsigned at);
      at = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (o_tx == 1'b0) begin
            at = cyc;
            return;
         end
      end
      check_eq("fall_timeout", 32'(o_tx), 32'd0);
   endtask

   task automatic wait_busy_low(input int max, output int unsigned at);
      at = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (o_busy == 1'b0) begin
            at = cyc;
            return;
         end
      end
      check_eq("busy_timeout", 32'(o_busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned t_fall, t_idle, n0;
      int          words0, bad, gap;
      i_reset = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;

      // Single word timing and byte order.
      do_reset();
      words0 = rx_words;
      push_word(16'hA55A, 1'b1);
      n0 = push_cyc;
      wait_fall(50, t_fall);
      check_eq("first_fall_latency", t_fall - n0, 32'd2);
      wait_busy_low(400, t_idle);
      check_eq("single_word_span", t_idle - t_fall, 32'd200);
      check_eq("single_word_count", 32'(rx_words - words0), 32'd1);

      // Reset in the middle of a byte abandons the frame.
      do_reset();
      words0 = rx_words;
      push_word(16'h1234, 1'b1);
      wait_fall(50, t_fall);
      repeat (45) @(negedge clk);
      do_reset();
      bad = 0;
      repeat (300) begin
         @(negedge clk);
         if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
      end
      check_eq("post_reset_idle", 32'(bad), 32'd0);
      check_eq("post_reset_words", 32'(rx_words - words0), 32'd0);

      // Burst of three words, no gaps between frames.
      do_reset();
      words0 = rx_words;
      push_word(16'h0001, 1'b1);
      push_word(16'h0002, 1'b1);
      push_word(16'h0003, 1'b1);
      wait_fall(50, t_fall);
      wait_busy_low(1000, t_idle);
      check_eq("burst_span", t_idle - t_fall, 32'd600);
      check_eq("burst_count", 32'(rx_words - words0), 32'd3);

      // Ten valids back to back: nine kept, the tenth dropped.
      do_reset();
      words0 = rx_words;
      for (int i = 0; i < 9; i++) push_word(16'h1100 + 16'(i), 1'b1);
      check_eq("ovf_before", 32'(o_overflow), 32'd0);
      push_word(16'h11FF, 1'b0);
      check_eq("ovf_set", 32'(o_overflow), 32'd1);
      check_eq("fifo_full_set", 32'(o_fifo_full), 32'd1);
      wait_busy_low(2500, t_idle);
      check_eq("ovf_sticky", 32'(o_overflow), 32'd1);
      check_eq("fifo_full_clear", 32'(o_fifo_full), 32'd0);
      check_eq("ovf_count", 32'(rx_words - words0), 32'd9);
      check_eq("ovf_sb_empty", 32'(sb_q.size()), 32'd0);

      // Push on the same edge the FSM pops from a full FIFO.
      do_reset();
      words0 = rx_words;
      push_word(16'h2200, 1'b1);
      n0 = push_cyc;
      @(posedge clk);
      #1;
      for (int i = 1; i < 9; i++) push_word(16'h2200 + 16'(i), 1'b1);
      while (cyc < n0 + 200) begin
         @(posedge clk);
         #1;
      end
      check_eq("coinc_full", 32'(o_fifo_full), 32'd1);
      push_word(16'h22AA, 1'b1);
      check_eq("coinc_push_edge", push_cyc - n0, 32'd201);
      check_eq("coinc_no_ovf", 32'(o_overflow), 32'd0);
      wait_busy_low(2500, t_idle);
      check_eq("coinc_no_ovf_end", 32'(o_overflow), 32'd0);
      check_eq("coinc_count", 32'(rx_words - words0), 32'd10);

      // Random words with random gaps.
      do_reset();
      words0 = rx_words;
      for (int i = 0; i < 100; i++) begin
         gap = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(220, 400));
         repeat (gap) @(posedge clk);
         push_word(16'($urandom), 1'b1);
      end
      repeat (3) @(posedge clk);
      wait_busy_low(3000, t_idle);
      check_eq("rand_no_ovf", 32'(o_overflow), 32'd0);
      check_eq("rand_count", 32'(rx_words - words0), 32'd100);
      check_eq("rand_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
